// File: rtl/stall_control.sv
// Pipeline interlock unit: the stall side of the hazard logic.
// Inserts one bubble for each load-use hazard that forwarding cannot
// cover, and runs the multdiv start/wait/release handshake, freezing
// F/D and D/X for the whole multdiv operation. Outputs are combinational
// from the FSM state and the D/X instruction registers.
`timescale 1ns/1ps

module stall_control #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7   // 2**CNT_W must exceed MD_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] decodeIR,
  input  logic [31:0] executeIR,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic        md_sel,
  output logic        md_exc,
  output logic        md_timeout
);

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;

  // Last WAIT cycle index before the release is forced.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_count;
  logic             exc_latched;
  logic             timeout_flag;

  logic [4:0] x_op;
  logic [4:0] x_rd;
  logic [4:0] x_aluop;
  logic       x_is_mul;
  logic       x_is_div;
  logic       x_is_md;
  logic       x_is_load;

  logic [4:0] d_op;
  logic [4:0] d_rd;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [4:0] src_a;
  logic [4:0] src_b;
  logic       src_a_valid;
  logic       src_b_valid;
  logic       load_use;

  // Instruction bits this unit never looks at (immediates, shamt, low bits).
  logic unused_ir_bits;
  assign unused_ir_bits = ^{executeIR[21:7], executeIR[1:0], decodeIR[11:0]};

  // Classify the X-stage instruction: multdiv start candidates and loads.
  always_comb begin
    x_op      = executeIR[31:27];
    x_rd      = executeIR[26:22];
    x_aluop   = executeIR[6:2];
    x_is_mul  = (x_op == OP_ALU) && (x_aluop == ALU_MUL);
    x_is_div  = (x_op == OP_ALU) && (x_aluop == ALU_DIV);
    x_is_md   = x_is_mul || x_is_div;
    x_is_load = (x_op == OP_LW);
  end

  // Pick the register sources of the D-stage instruction by opcode.
  // Store data is forwarded late, so sw only depends on its base register.
  always_comb begin
    d_op        = decodeIR[31:27];
    d_rd        = decodeIR[26:22];
    d_rs        = decodeIR[21:17];
    d_rt        = decodeIR[16:12];
    src_a       = d_rs;
    src_b       = d_rt;
    src_a_valid = 1'b1;
    src_b_valid = 1'b0;
    case (d_op)
      OP_ALU: begin
        src_a       = d_rs;
        src_b       = d_rt;
        src_b_valid = 1'b1;
      end
      OP_BNE, OP_BLT: begin
        src_a       = d_rd;
        src_b       = d_rs;
        src_b_valid = 1'b1;
      end
      OP_JR: begin
        src_a = d_rd;
      end
      OP_SW: begin
        src_a = d_rs;
      end
      default: begin
        src_a = d_rs;
      end
    endcase
  end

  // A load in X whose nonzero destination feeds D cannot be forwarded in time.
  always_comb begin
    load_use = x_is_load && (x_rd != 5'd0) &&
               ((src_a_valid && (src_a == x_rd)) ||
                (src_b_valid && (src_b == x_rd)));
  end

  // Multdiv handshake FSM, WAIT cycle counter, latched exception and sticky timeout.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      wait_count   <= '0;
      exc_latched  <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (x_is_md) begin
            state      <= WAIT;
            wait_count <= '0;
          end
        end
        WAIT: begin
          wait_count <= wait_count + 1'b1;
          if (md_resultRDY) begin
            exc_latched <= md_exception;
            state       <= RELEASE;
          end else if (wait_count == TIMEOUT_LAST) begin
            exc_latched  <= 1'b1;
            timeout_flag <= 1'b1;
            state        <= RELEASE;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Drive latch enables, bubble mux and multdiv controls; all forced low in reset.
  always_comb begin
    stall_fd   = 1'b0;
    stall_dx   = 1'b0;
    bubble_dx  = 1'b0;
    ctrl_MULT  = 1'b0;
    ctrl_DIV   = 1'b0;
    md_sel     = 1'b0;
    md_exc     = 1'b0;
    md_timeout = 1'b0;
    if (reset) begin
      md_timeout = timeout_flag;
      case (state)
        IDLE: begin
          if (x_is_md) begin
            ctrl_MULT = x_is_mul;
            ctrl_DIV  = x_is_div;
            stall_fd  = 1'b1;
            stall_dx  = 1'b1;
          end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end
        end
        WAIT: begin
          stall_fd = 1'b1;
          stall_dx = 1'b1;
        end
        RELEASE: begin
          md_sel = 1'b1;
          md_exc = exc_latched;
        end
        default: begin
          stall_fd = 1'b0;
        end
      endcase
    end
  end

endmodule
